mem_latency_model: RTL and testbench

Cycle-accurate memory responder that sits directly downstream of the Vortex core's memory port: it consumes `mem_req_*`, applies writes to an internal line store, and returns read data with the original tag on `mem_rsp_*` after a fixed latency. It replaces ad-hoc random response stimulus in simulation benches with a deterministic, back-pressure-correct memory. Reads are returned in acceptance order; writes produce no response.

---
 rtl/mem_model_pkg.sv | 24 ++
 rtl/mem_rsp_fifo.sv | 52 +++++
 rtl/mem_latency_model.sv | 134 +++++++++++++
 tb/tb_mem_latency_model.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared widths and request/response bundles for the memory latency model.
// LAT_MAX bounds the read pipeline depth accepted by the top level.
package mem_model_pkg;

  localparam int DATA_W  = 512;
  localparam int ADDR_W  = 26;
  localparam int TAG_W   = 7;
  localparam int BYTE_W  = DATA_W / 8;
  localparam int LAT_MAX = 16;

  typedef struct packed {
    logic              rw;
    logic [BYTE_W-1:0] byteen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// First-word-fall-through FIFO; head is read straight from registered storage, zero when empty.
// Push while full and pop while empty are ignored; the caller's credit scheme prevents both.
module mem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign empty_o  = (count_o == '0);
  assign full_o   = (count_o == (AW+1)'(DEPTH));
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  // Forcing zero on empty keeps the data/tag outputs at their reset values.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/mem_latency_model.sv
// Deterministic memory responder: byte-masked writes, reads returned in order after LATENCY+1 cycles.
// Requests are throttled by a credit count of reads in flight so the response FIFO never overflows.
module mem_latency_model
  import mem_model_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 7,
  parameter int LINES_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int RSP_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_req_valid,
  input  logic                      mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0]   mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic [DATA_WIDTH-1:0]     mem_req_data,
  input  logic [TAG_WIDTH-1:0]      mem_req_tag,
  output logic                      mem_req_ready,
  output logic                      mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]     mem_rsp_data,
  output logic [TAG_WIDTH-1:0]      mem_rsp_tag,
  input  logic                      mem_rsp_ready,
  output logic                      busy,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
);

  localparam int OW = $clog2(RSP_DEPTH) + 1;

  if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("mem_latency_model: LATENCY out of range");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_latency_model: RSP_DEPTH must be a power of two >= 2");
  end
  if (DATA_WIDTH != DATA_W || ADDR_WIDTH != ADDR_W || TAG_WIDTH != TAG_W) begin : g_bad_width
    $error("mem_latency_model: widths must match mem_model_pkg");
  end

  mem_req_t                req;
  logic [DATA_WIDTH-1:0]   store_q [2**LINES_LOG2];
  logic [LINES_LOG2-1:0]   idx;
  mem_rsp_t                pipe_q [LATENCY];
  logic [LATENCY-1:0]      pipe_vld_q;
  mem_rsp_t                rsp_head;
  logic                    fifo_full, fifo_empty;
  logic [OW-1:0]           fifo_count;
  logic [OW-1:0]           outstanding;
  logic                    rd_acc, wr_acc, rsp_pop;
  logic [31:0]             rd_count_q, rd_count_d;
  logic [31:0]             wr_count_q, wr_count_d;
  logic                    unused_bits;

  assign req = '{rw: mem_req_rw, byteen: mem_req_byteen, addr: mem_req_addr,
                 data: mem_req_data, tag: mem_req_tag};
  assign idx = req.addr[LINES_LOG2-1:0];
  // Upper address bits alias onto the same line by design.
  assign unused_bits = ^{req.addr[ADDR_WIDTH-1:LINES_LOG2], fifo_full};

  assign outstanding   = OW'($countones(pipe_vld_q)) + fifo_count;
  assign mem_req_ready = reset && (outstanding < OW'(RSP_DEPTH));
  assign rd_acc        = mem_req_valid && mem_req_ready && !req.rw;
  assign wr_acc        = mem_req_valid && mem_req_ready && req.rw;
  assign rsp_pop       = mem_rsp_valid && mem_rsp_ready;
  assign busy          = (outstanding != '0);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (req.byteen[b]) begin
          store_q[idx][8*b +: 8] <= req.data[8*b +: 8];
        end
      end
    end
  end

  // Payload stages carry no reset; only the valid bits decide what reaches the FIFO.
  always_ff @(posedge clk) begin
    pipe_q[0] <= '{data: store_q[idx], tag: req.tag};
    for (int i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  mem_rsp_fifo #(
    .WIDTH ($bits(mem_rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (pipe_vld_q[LATENCY-1]),
    .push_dat_i (pipe_q[LATENCY-1]),
    .pop_i      (rsp_pop),
    .head_o     (rsp_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign mem_rsp_valid = !fifo_empty;
  assign mem_rsp_data  = rsp_head.data;
  assign mem_rsp_tag   = rsp_head.tag;

  assign rd_count_d = rd_count_q + 32'(rd_acc);
  assign wr_count_d = wr_count_q + 32'(wr_acc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_latency_model.sv
// Scoreboarded bench: a line-level memory model predicts every read response and credit state.
module tb_mem_latency_model;

  localparam int DW = 512, AW = 26, TW = 7, LL = 10, LAT = 4, DEPTH = 8, BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req_valid = 1'b0;
  logic          mem_req_rw = 1'b0;
  logic [BW-1:0] mem_req_byteen = '0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [DW-1:0] mem_req_data = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready = 1'b0;
  logic          busy;
  logic [31:0]   rd_count, wr_count;

  mem_latency_model #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .TAG_WIDTH (TW),
    .LINES_LOG2 (LL), .LATENCY (LAT), .RSP_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .busy           (busy),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  bit   rand_rdy = 1'b0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_seen = reset;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 mem_rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  logic [DW-1:0] line_m [int];
  exp_t          exp_q [$];
  int            out_m = 0, rd_m = 0, wr_m = 0;
  int            checks = 0, errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_be();
    logic [BW-1:0] v;
    for (int k = 0; k < BW / 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: checks credit/counter state, then retires responses and records new requests.
  always @(negedge clk) begin
    if (!rst_seen) begin
      chk("rst_rsp_valid", DW'(mem_rsp_valid), '0);
      chk("rst_rsp_data", mem_rsp_data, '0);
      chk("rst_rsp_tag", DW'(mem_rsp_tag), '0);
    end
    chk("req_ready", DW'(mem_req_ready), DW'(reset && (out_m < DEPTH)));
    chk("busy", DW'(busy), DW'(out_m != 0));
    chk("rd_count", DW'(rd_count), DW'(rd_m));
    chk("wr_count", DW'(wr_count), DW'(wr_m));
    if (!reset) begin
      exp_q.delete();
      out_m = 0;
      rd_m  = 0;
      wr_m  = 0;
    end else begin
      if (mem_rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp_valid", DW'(mem_rsp_valid), '0);
        end else begin
          chk("rsp_data", mem_rsp_data, exp_q[0].data);
          chk("rsp_tag", DW'(mem_rsp_tag), DW'(exp_q[0].tag));
          if (mem_rsp_ready) begin
            void'(exp_q.pop_front());
            out_m--;
          end
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        int            ix;
        logic [DW-1:0] ln;
        ix = int'(mem_req_addr % (1 << LL));
        ln = line_m.exists(ix) ? line_m[ix] : 'x;
        if (mem_req_rw) begin
          for (int b = 0; b < BW; b++)
            if (mem_req_byteen[b]) ln[8*b +: 8] = mem_req_data[8*b +: 8];
          line_m[ix] = ln;
          wr_m++;
        end else begin
          exp_q.push_back('{data: ln, tag: mem_req_tag});
          out_m++;
          rd_m++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                      input logic [DW-1:0] data, input logic [TW-1:0] tag, output int acc_cyc);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = data;
    mem_req_tag    = tag;
    acc_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_req_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) chk("req_accept_timeout", DW'(mem_req_ready), DW'(1));
    @(posedge clk);
    #1 mem_req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", DW'(exp_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            a, got, nrd;
    logic [DW-1:0] d;
    logic [AW-1:0] ad;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    mem_rsp_ready = 1'b1;

    // Full write then read: exact latency and contents.
    send(1'b1, 26'h005, '1, {64{8'hA5}}, '0, a);
    send(1'b0, 26'h005, '0, '0, 7'h11, a);
    got = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rsp_valid) begin
        got = cyc;
        break;
      end
    end
    chk("rd_latency", DW'(got), DW'(a + LAT + 1));
    chk("t1_rsp_data", mem_rsp_data, {64{8'hA5}});
    chk("t1_rd_count", DW'(rd_count), DW'(1));
    chk("t1_wr_count", DW'(wr_count), DW'(1));
    @(posedge clk);
    #1;

    // Single-byte write, then read the line directly and through an alias.
    d = rand_line();
    d[7:0] = 8'hFF;
    send(1'b1, 26'h005, BW'(1), d, '0, a);
    send(1'b0, 26'h005, '0, '0, 7'h22, a);
    send(1'b0, 26'h405, '0, '0, 7'h23, a);
    drain();

    // Fill all credits with the consumer stalled.
    mem_rsp_ready = 1'b0;
    for (int t = 0; t < DEPTH; t++) send(1'b0, 26'h005, '0, '0, TW'(t), a);
    @(negedge clk);
    chk("req_ready_full", DW'(mem_req_ready), '0);
    chk("busy_full", DW'(busy), DW'(1));
    @(posedge clk);
    #1 mem_rsp_ready = 1'b1;
    drain();

    // Random traffic with a randomly stalling consumer.
    for (int k = 0; k < 16; k++) begin
      ad = AW'($urandom);
      ad[LL-1:0] = LL'(k);
      send(1'b1, ad, '1, rand_line(), '0, a);
    end
    rand_rdy = 1'b1;
    nrd = 0;
    while (nrd < 32) begin
      ad = AW'($urandom);
      ad[LL-1:0] = LL'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) begin
        send(1'b1, ad, rand_be(), rand_line(), '0, a);
      end else begin
        send(1'b0, ad, '0, '0, TW'($urandom), a);
        nrd++;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 mem_rsp_ready = 1'b1;
    drain();

    // Reset while reads are still in the pipeline.
    mem_rsp_ready = 1'b0;
    for (int t = 0; t < 3; t++) send(1'b0, 26'h005, '0, '0, TW'(t + 40), a);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_rd_count", DW'(rd_count), '0);
    chk("post_rst_busy", DW'(busy), '0);
    chk("post_rst_rsp_valid", DW'(mem_rsp_valid), '0);
    @(posedge clk);
    #1 mem_rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_empty", DW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
